timer_countdown_ctrl: RTL
=========================

Name: timer_countdown_ctrl

Overview:
Receiving end of the keypad digit interface. Consumes the BCD digit bus D, the active-low load strobe loadn and the 1 Hz tick pgt_1Hz. Shifts entered digits into an mm:ss BCD register and counts it down once per second under start/stop/clear control. Drives the cook-time display digits, the magnetron enable and the done indication.

Parameters:
DONE_TICKS, 3, number of pgt_1Hz rising edges that the DONE state (done=1) is held before returning to ENTRY
MAX_MIN_TENS, 9, largest allowed minutes-tens digit; a shift that would exceed it is ignored

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
D  input  4  BCD digit from keypad encoder, valid while loadn=0
loadn  input  1  active-low digit load strobe, synchronous to clock
pgt_1Hz  input  1  1 Hz tick, synchronous to clock, rising edge counts
startn  input  1  active-low start request, level
stopn  input  1  active-low stop/pause request, level
clearn  input  1  active-low clear request, level
sec_ones  output  4  BCD seconds units
sec_tens  output  4  BCD seconds tens
min_ones  output  4  BCD minutes units
min_tens  output  4  BCD minutes tens
mag_on  output  1  magnetron enable, 1 only in RUNNING
done  output  1  1 only in DONE
zero  output  1  all four digits equal 0 (combinational from registers)

Behaviour:
- Reset: all digits 0, state ENTRY, mag_on=0, done=0, zero=1, done tick counter 0, loadn edge register 1, pgt_1Hz edge register 1. Reset mid-count aborts immediately with no residual tick.
- Edge detect: load event = loadn registered 1 and now 0. Tick event = pgt_1Hz registered 0 and now 1. Each event is exactly one cycle and acts in the cycle after detection (1-cycle latency).
- States: ENTRY, RUNNING, PAUSED, DONE.
- ENTRY: on a load event with D<=9, shift min_tens<-min_ones<-sec_tens<-sec_ones<-D. A load event with D>9 is ignored, as is one where min_ones>MAX_MIN_TENS. Start with zero=0 goes to RUNNING. Start with zero=1 stays in ENTRY. Clear zeroes all digits.
- RUNNING: each tick decrements BCD mm:ss. sec_ones 0 borrows from sec_tens. Seconds 00 borrows one minute and wraps to 59. Minutes borrow tens-to-units in BCD. sec_tens>5 entered by the user counts down naturally (e.g. 00:90 -> 00:89). When the decrement reaches 00:00, the next cycle goes to DONE. Stop goes to PAUSED. Clear goes to ENTRY with digits 0. Load events are ignored.
- PAUSED: digits hold and ticks are ignored. Start goes to RUNNING. Stop or clear goes to ENTRY with digits 0. Loads are ignored.
- DONE: digits are 0. Counts ticks. After DONE_TICKS ticks, or on any clear/stop, goes to ENTRY.
- Priority when simultaneous: reset > clear > stop > start > tick > load. A stop in the same cycle as a tick means no decrement.
- Held level inputs act once per state: startn held low while RUNNING has no effect.

Optional Feature:
TIMER_ADD30_EN. When defined, a start request in RUNNING (falling edge of startn) adds 30 s in BCD. sec_tens+3 with carry into the minutes at >=6, i.e. subtract 6 and add 1 minute. The result saturates at 99:59. Without the macro, start in RUNNING is ignored.

Decomposition:
- Package timer_pkg holds the state enum (ENTRY, RUNNING, PAUSED, DONE), the BCD_MAX=9 and SEC_TENS_MAX=5 constants, and the 4-digit mmss struct.
- One natural sub-module: bcd_mmss_dec, a combinational mm:ss BCD decrement with a zero flag, instantiated once.
- The add-30 logic stays inline under the macro.

Test Plan:
- Reset, then load D=1,3,0 (loadn pulses) -> digits 0,1,3,0 (01:30), zero=0, state ENTRY.
- From 01:30, assert startn, then apply 31 ticks -> 01:29 after the first tick, 00:59 after the 31st. mag_on=1 throughout.
- Load 00:02 and start. 2 ticks -> 00:00, then DONE, done=1, mag_on=0. After 3 more ticks, back to ENTRY with done=0.
- Running at 00:45: stopn low on the same cycle as a tick -> PAUSED at 00:45. Ticks produce no change. Start -> resumes at 00:45.
- Load D=0xA in ENTRY -> ignored, digits unchanged. Start with 00:00 -> stays in ENTRY, mag_on=0. Reset asserted while RUNNING at 05:10 -> all outputs at reset values within the same cycle.
- TIMER_ADD30_EN defined, RUNNING at 00:45: startn falling edge -> 01:15. At 99:50 -> 99:59.

Source files
------------

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the countdown timer controller.
//   state_t : controller states (ENTRY, RUNNING, PAUSED, DONE)
//   mmss_t  : four BCD digits of the mm:ss cook time, minutes tens in the MSBs
//   BCD_MAX, SEC_TENS_MAX : largest digit values used when borrowing
// ---------------------------------------------------------------------------
package timer_pkg;

   typedef enum logic [1:0] {
      ENTRY   = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [3:0] BCD_MAX      = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;

   typedef struct packed {
      logic [3:0] minTens;
      logic [3:0] minOnes;
      logic [3:0] secTens;
      logic [3:0] secOnes;
   } mmss_t;

endpackage

// File: rtl/bcd_mmss_dec.sv
// ---------------------------------------------------------------------------
// bcd_mmss_dec
// Purely combinational one-second decrement of an mm:ss BCD value.
// Ports:
//   i_value : current mm:ss digits
//   o_value : i_value minus one second (BCD, seconds wrap 00 -> 59)
//   o_zero  : high when all four digits of i_value are zero
// The 00:00 input wraps to a meaningless value; the caller never uses the
// decremented result when o_zero is set.
// ---------------------------------------------------------------------------
module bcd_mmss_dec
   import timer_pkg::*;
(
   input  mmss_t i_value,
   output mmss_t o_value,
   output logic  o_zero
);

   // Borrow chain: seconds units, seconds tens (wrapping to 5), minutes units,
   // minutes tens. A user-entered seconds tens above 5 simply counts down.
   always_comb begin
      o_value = i_value;
      o_zero  = (i_value == '0);
      if (i_value.secOnes != 4'd0) begin
         o_value.secOnes = i_value.secOnes - 4'd1;
      end else begin
         o_value.secOnes = BCD_MAX;
         if (i_value.secTens != 4'd0) begin
            o_value.secTens = i_value.secTens - 4'd1;
         end else begin
            o_value.secTens = SEC_TENS_MAX;
            if (i_value.minOnes != 4'd0) begin
               o_value.minOnes = i_value.minOnes - 4'd1;
            end else begin
               o_value.minOnes = BCD_MAX;
               o_value.minTens = i_value.minTens - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/timer_countdown_ctrl.sv
// ---------------------------------------------------------------------------
// timer_countdown_ctrl
// Receives keypad digits, builds an mm:ss BCD cook time and counts it down
// once per 1 Hz tick under start/stop/clear control.
// Ports:
//   clock, reset          : system clock, async active-high reset
//   D, loadn              : BCD digit and active-low load strobe
//   pgt_1Hz               : 1 Hz tick, counted on its rising edge
//   startn, stopn, clearn : active-low command levels
//   sec_ones..min_tens    : displayed cook-time digits
//   mag_on, done, zero    : RUNNING, DONE and all-digits-zero indications
// Optional build macro TIMER_ADD30_EN: a new start request while RUNNING
// adds 30 seconds, saturating at 99:59.
// ---------------------------------------------------------------------------
module timer_countdown_ctrl
   import timer_pkg::*;
#(
   parameter int         DONE_TICKS   = 3,
   parameter logic [3:0] MAX_MIN_TENS = 4'd9
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] D,
   input  logic       loadn,
   input  logic       pgt_1Hz,
   input  logic       startn,
   input  logic       stopn,
   input  logic       clearn,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       mag_on,
   output logic       done,
   output logic       zero
);

   localparam int CntW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

   state_t          r_state;
   state_t          w_nextState;
   mmss_t           r_digits;
   mmss_t           w_nextDigits;
   mmss_t           w_decDigits;
   logic            w_zero;
   logic [CntW-1:0] r_doneCnt;

   logic r_loadnQ;
   logic r_pgtQ;
   logic r_startnQ;
   logic r_stopnQ;
   logic r_clearnQ;

   logic w_loadEv;
   logic w_tickEv;
   logic w_startEv;
   logic w_stopEv;
   logic w_clearEv;
   logic w_loadOk;
   logic w_doneLast;

   // Previous-cycle copies of the strobes and command levels. They reset to
   // the inactive level so nothing fires straight out of reset. Commands are
   // taken on their asserting edge, so a level held low acts only once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_loadnQ  <= 1'b1;
         r_pgtQ    <= 1'b1;
         r_startnQ <= 1'b1;
         r_stopnQ  <= 1'b1;
         r_clearnQ <= 1'b1;
      end else begin
         r_loadnQ  <= loadn;
         r_pgtQ    <= pgt_1Hz;
         r_startnQ <= startn;
         r_stopnQ  <= stopn;
         r_clearnQ <= clearn;
      end
   end

   assign w_loadEv   = r_loadnQ & ~loadn;
   assign w_tickEv   = ~r_pgtQ & pgt_1Hz;
   assign w_startEv  = r_startnQ & ~startn;
   assign w_stopEv   = r_stopnQ & ~stopn;
   assign w_clearEv  = r_clearnQ & ~clearn;
   assign w_loadOk   = (D <= BCD_MAX) && (r_digits.minOnes <= MAX_MIN_TENS);
   assign w_doneLast = (r_doneCnt == CntW'(DONE_TICKS - 1));

   bcd_mmss_dec uDec (
      .i_value (r_digits),
      .o_value (w_decDigits),
      .o_zero  (w_zero)
   );

`ifdef TIMER_ADD30_EN
   mmss_t      w_add30;
   logic [3:0] w_secTensSum;

   // Add 30 s: bump seconds tens by 3 and carry a minute once it passes 5.
   // Carrying out of 99 minutes clamps the whole value to 99:59.
   always_comb begin
      w_add30      = r_digits;
      w_secTensSum = r_digits.secTens + 4'd3;
      if (w_secTensSum > SEC_TENS_MAX) begin
         if ((r_digits.minTens == BCD_MAX) && (r_digits.minOnes == BCD_MAX)) begin
            w_add30.secTens = SEC_TENS_MAX;
            w_add30.secOnes = BCD_MAX;
         end else begin
            w_add30.secTens = w_secTensSum - 4'd6;
            if (r_digits.minOnes == BCD_MAX) begin
               w_add30.minOnes = 4'd0;
               w_add30.minTens = r_digits.minTens + 4'd1;
            end else begin
               w_add30.minOnes = r_digits.minOnes + 4'd1;
            end
         end
      end else begin
         w_add30.secTens = w_secTensSum;
      end
   end
`endif

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ENTRY;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Each branch tests events in priority order
   // clear > stop > start > tick > load. A running count that has reached
   // 00:00 moves to DONE on the following cycle.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ENTRY: begin
            if (!w_clearEv && !w_stopEv && w_startEv && !w_zero) begin
               w_nextState = RUNNING;
            end
         end
         RUNNING: begin
            if (w_clearEv) begin
               w_nextState = ENTRY;
            end else if (w_stopEv) begin
               w_nextState = PAUSED;
`ifdef TIMER_ADD30_EN
            end else if (w_startEv) begin
               w_nextState = RUNNING;
`endif
            end else if (w_zero) begin
               w_nextState = DONE;
            end
         end
         PAUSED: begin
            if (w_clearEv || w_stopEv) begin
               w_nextState = ENTRY;
            end else if (w_startEv) begin
               w_nextState = RUNNING;
            end
         end
         DONE: begin
            if (w_clearEv || w_stopEv || (w_tickEv && w_doneLast)) begin
               w_nextState = ENTRY;
            end
         end
         default: w_nextState = ENTRY;
      endcase
   end

   // Output logic decoded from the current state only.
   always_comb begin
      mag_on = 1'b0;
      done   = 1'b0;
      case (r_state)
         RUNNING: mag_on = 1'b1;
         DONE:    done   = 1'b1;
         default: ;
      endcase
   end

   // Digit datapath, using the same priority order as the state logic.
   // Entry shifts a valid digit in from the right; running decrements on a
   // tick; leaving through clear or a stop from PAUSED zeroes the display.
   always_comb begin
      w_nextDigits = r_digits;
      case (r_state)
         ENTRY: begin
            if (w_clearEv) begin
               w_nextDigits = '0;
            end else if (!w_stopEv && !w_startEv && w_loadEv && w_loadOk) begin
               w_nextDigits = '{minTens: r_digits.minOnes,
                                minOnes: r_digits.secTens,
                                secTens: r_digits.secOnes,
                                secOnes: D};
            end
         end
         RUNNING: begin
            if (w_clearEv) begin
               w_nextDigits = '0;
            end else if (w_stopEv) begin
               w_nextDigits = r_digits;
`ifdef TIMER_ADD30_EN
            end else if (w_startEv) begin
               w_nextDigits = w_add30;
`endif
            end else if (w_tickEv && !w_zero) begin
               w_nextDigits = w_decDigits;
            end
         end
         PAUSED: begin
            if (w_clearEv || w_stopEv) begin
               w_nextDigits = '0;
            end
         end
         DONE:    w_nextDigits = '0;
         default: w_nextDigits = '0;
      endcase
   end

   // Digit register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_digits <= '0;
      end else begin
         r_digits <= w_nextDigits;
      end
   end

   // Counts ticks spent in DONE; cleared whenever DONE is left or not active.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_doneCnt <= '0;
      end else if (r_state != DONE || w_nextState != DONE) begin
         r_doneCnt <= '0;
      end else if (w_tickEv) begin
         r_doneCnt <= r_doneCnt + CntW'(1);
      end
   end

   assign sec_ones = r_digits.secOnes;
   assign sec_tens = r_digits.secTens;
   assign min_ones = r_digits.minOnes;
   assign min_tens = r_digits.minTens;
   assign zero     = w_zero;

endmodule
